// File: rtl/pwmtx_if.sv
// pwmtx_if: control and status bundle for the pwmtx servo PWM generator.
//
// Signals (named from the DUT's point of view):
//   enable_in        - level, request frame generation
//   width_in         - requested pulse width in clocks
//   width_valid_in   - one-cycle strobe, loads width_in into the shadow register
//   pulse_out        - registered PWM output
//   period_start_out - one-cycle strobe in the first cycle of every frame
//   active_width_out - width in use for the current frame
//   clamped_out      - last accepted write was clamped
//   busy_out         - high while frames are being generated
//   state_dbg        - FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: width_valid_in is a valid-only strobe with no ready. Every
// cycle with width_valid_in high is an accepted write of width_in,
// regardless of state. There is no backpressure.
interface pwmtx_if #(
  parameter int unsigned SIZE = 32
);
  logic            enable_in;
  logic [SIZE-1:0] width_in;
  logic            width_valid_in;
  logic            pulse_out;
  logic            period_start_out;
  logic [SIZE-1:0] active_width_out;
  logic            clamped_out;
  logic            busy_out;
  logic            state_dbg;

  modport master (
    output enable_in, width_in, width_valid_in,
    input  pulse_out, period_start_out, active_width_out, clamped_out,
           busy_out, state_dbg
  );

  modport slave (
    input  enable_in, width_in, width_valid_in,
    output pulse_out, period_start_out, active_width_out, clamped_out,
           busy_out, state_dbg
  );
endinterface

// File: rtl/pwmtx.sv
// pwmtx: servo-style PWM pulse generator.
//
// The generator emits one high pulse per fixed frame of PERIOD clocks. The
// pulse width is given in clocks and is clamped to [MIN_WIDTH, MAX_WIDTH].
// Width writes go to a shadow register. The shadow register is copied into
// the active width only at a frame start, so the output never carries a
// glitch or a runt pulse.
//
// Ports:
//   clk_in     - system clock
//   reset_n_in - asynchronous active-low reset
//   bus        - pwmtx_if.slave (enable, width write strobe, PWM and status)
module pwmtx #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned SYSCLK    = 25000000,
  parameter int unsigned PERIOD    = 500000,
  parameter int unsigned MIN_WIDTH = 25000,
  parameter int unsigned MAX_WIDTH = 50000
) (
  input  logic    clk_in,
  input  logic    reset_n_in,
  pwmtx_if.slave  bus
);

  // Elaboration-time parameter legality check. SYSCLK is documentation only.
  if (MIN_WIDTH == 0 || MIN_WIDTH > MAX_WIDTH || MAX_WIDTH >= PERIOD ||
      SYSCLK == 0 ||
      (64'(PERIOD) > ((64'd1 << SIZE) - 64'd1))) begin : g_param_check
    $error("pwmtx: illegal parameter combination");
  end

  localparam logic [SIZE-1:0] MIN_L  = SIZE'(MIN_WIDTH);
  localparam logic [SIZE-1:0] MAX_L  = SIZE'(MAX_WIDTH);
  localparam logic [SIZE-1:0] LAST_L = SIZE'(PERIOD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] count, count_nxt;
  logic [SIZE-1:0] active, active_nxt;
  logic [SIZE-1:0] shadow, shadow_nxt;
  logic            pulse, pulse_nxt;
  logic            pstart, pstart_nxt;
  logic            clamped, clamped_nxt;

  logic [SIZE-1:0] clamp_w;
  logic            clamp_hit;
  logic [SIZE-1:0] next_shadow;
  logic [SIZE-1:0] count_inc;

  // Saturate the requested width into the legal range (unsigned compare).
  always_comb begin
    clamp_w   = bus.width_in;
    clamp_hit = 1'b0;
    if (bus.width_in < MIN_L) begin
      clamp_w   = MIN_L;
      clamp_hit = 1'b1;
    end else if (bus.width_in > MAX_L) begin
      clamp_w   = MAX_L;
      clamp_hit = 1'b1;
    end
  end

  // Shadow value as it will be after this edge. A write on a frame-start
  // edge therefore already applies to the frame that is starting.
  assign next_shadow = bus.width_valid_in ? clamp_w : shadow;

  // count never exceeds PERIOD-2 when incremented, so this cannot wrap.
  assign count_inc = count + 1'b1;

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    active_nxt  = active;
    pulse_nxt   = pulse;
    pstart_nxt  = 1'b0;
    shadow_nxt  = next_shadow;
    clamped_nxt = bus.width_valid_in ? clamp_hit : clamped;

    case (state)
      IDLE: begin
        count_nxt = '0;
        pulse_nxt = 1'b0;
        if (bus.enable_in) begin
          state_nxt  = RUN;
          active_nxt = next_shadow;
          pulse_nxt  = 1'b1;
          pstart_nxt = 1'b1;
        end
      end
      RUN: begin
        if (count != LAST_L) begin
          count_nxt = count_inc;
          pulse_nxt = (count_inc < active);
        end else if (bus.enable_in) begin
          // Back-to-back frame. enable_in is only looked at here, so a frame
          // that has started always runs to its end.
          count_nxt  = '0;
          active_nxt = next_shadow;
          pulse_nxt  = 1'b1;
          pstart_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
          count_nxt = '0;
          pulse_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        pulse_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= IDLE;
      count   <= '0;
      active  <= MIN_L;
      shadow  <= MIN_L;
      pulse   <= 1'b0;
      pstart  <= 1'b0;
      clamped <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      active  <= active_nxt;
      shadow  <= shadow_nxt;
      pulse   <= pulse_nxt;
      pstart  <= pstart_nxt;
      clamped <= clamped_nxt;
    end
  end

  assign bus.pulse_out        = pulse;
  assign bus.period_start_out = pstart;
  assign bus.active_width_out = active;
  assign bus.clamped_out      = clamped;
  assign bus.busy_out         = (state == RUN);
  assign bus.state_dbg        = state;

endmodule

// File: tb/tb_pwmtx.sv
// tb_pwmtx: self-checking bench for pwmtx with small frame parameters.
module tb_pwmtx;
  localparam int unsigned SIZE   = 32;
  localparam int unsigned PERIOD = 100;
  localparam int unsigned MIN_W  = 10;
  localparam int unsigned MAX_W  = 40;

  // ---------------- clock / reset ----------------
  logic clk_in     = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  pwmtx_if #(.SIZE(SIZE)) bus();

  pwmtx #(
    .SIZE(SIZE), .SYSCLK(25000000), .PERIOD(PERIOD),
    .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Frame-level view: a frame starts at edge m_fstart and the output is
  // high for the first m_width clocks after that edge.
  int          edge_n = 0;
  bit          m_run;
  int          m_fstart;
  int unsigned m_width;
  int unsigned m_shadow;
  bit          m_clamped;

  function automatic int unsigned ref_clamp(input logic [31:0] w);
    if (w < MIN_W) return MIN_W;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  function automatic int m_pos();
    return edge_n - m_fstart;
  endfunction

  task automatic model_reset();
    m_run     = 1'b0;
    m_fstart  = 0;
    m_width   = MIN_W;
    m_shadow  = MIN_W;
    m_clamped = 1'b0;
  endtask

  task automatic model_edge();
    edge_n++;
    if (!reset_n_in) return;
    if (bus.width_valid_in) begin
      m_shadow  = ref_clamp(bus.width_in);
      m_clamped = (bus.width_in < MIN_W) || (bus.width_in > MAX_W);
    end
    if (m_run) begin
      if (m_pos() == int'(PERIOD)) begin
        if (bus.enable_in) begin
          m_fstart = edge_n;
          m_width  = m_shadow;
        end else begin
          m_run = 1'b0;
        end
      end
    end else if (bus.enable_in) begin
      m_run    = 1'b1;
      m_fstart = edge_n;
      m_width  = m_shadow;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic compare_all();
    check("pulse",   bus.pulse_out,        m_run && (m_pos() < int'(m_width)));
    check("pstart",  bus.period_start_out, m_run && (m_pos() == 0));
    check("busy",    bus.busy_out,         m_run);
    check("state",   bus.state_dbg,        m_run);
    check("active",  bus.active_width_out, m_width);
    check("clamped", bus.clamped_out,      m_clamped);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic drive(input bit en, input bit wv, input logic [31:0] w);
    bus.enable_in      = en;
    bus.width_valid_in = wv;
    bus.width_in       = w;
    step();
    bus.width_valid_in = 1'b0;
  endtask

  task automatic run_to_pos(input int target);
    int k = 0;
    while (!(m_run && m_pos() == target) && k < 3 * int'(PERIOD)) begin
      step();
      k++;
    end
    check("reach_pos_timeout", k < 3 * int'(PERIOD), 1);
  endtask

  typedef struct {
    logic [31:0] w;
    int unsigned exp_w;
    bit          exp_c;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi;
    int          k;
    int unsigned prev_exp;
    bit          en;

    tbl[0] = '{32'd25,         25, 1'b0};
    tbl[1] = '{32'd5,          10, 1'b1};
    tbl[2] = '{32'd1000,       40, 1'b1};
    tbl[3] = '{32'd0,          10, 1'b1};
    tbl[4] = '{32'd10,         10, 1'b0};
    tbl[5] = '{32'd40,         40, 1'b0};
    tbl[6] = '{32'd41,         40, 1'b1};
    tbl[7] = '{32'd9,          10, 1'b1};
    tbl[8] = '{32'hFFFF_FFFF,  40, 1'b1};
    tbl[9] = '{32'd17,         17, 1'b0};

    // Reset state
    bus.enable_in      = 1'b0;
    bus.width_valid_in = 1'b0;
    bus.width_in       = '0;
    model_reset();
    repeat (3) step();
    check("rst_pulse",   bus.pulse_out, 0);
    check("rst_active",  bus.active_width_out, MIN_W);
    check("rst_clamped", bus.clamped_out, 0);
    check("rst_busy",    bus.busy_out, 0);
    reset_n_in = 1'b1;
    repeat (2) step();

    // Enable with no write: 10-high / 90-low frames
    drive(1'b1, 1'b0, '0);
    check("start_pstart", bus.period_start_out, 1);
    check("start_pulse",  bus.pulse_out, 1);
    repeat (250) step();

    // Table-driven width writes, each issued mid-frame
    prev_exp = MIN_W;
    foreach (tbl[i]) begin
      run_to_pos(50);
      check("tbl_hold_before", bus.active_width_out, prev_exp);
      drive(1'b1, 1'b1, tbl[i].w);
      check("tbl_hold_after", bus.active_width_out, prev_exp);
      check("tbl_clamped_now", bus.clamped_out, tbl[i].exp_c);
      run_to_pos(int'(PERIOD) - 1);
      step();
      check("tbl_pstart",  bus.period_start_out, 1);
      check("tbl_active",  bus.active_width_out, tbl[i].exp_w);
      check("tbl_clamped", bus.clamped_out, tbl[i].exp_c);
      hi = 0;
      while (bus.pulse_out === 1'b1 && hi < int'(PERIOD)) begin
        hi++;
        step();
      end
      check("tbl_high_len", hi, tbl[i].exp_w);
      prev_exp = tbl[i].exp_w;
    end

    // Write on the exact frame-end edge applies to the new frame
    run_to_pos(int'(PERIOD) - 1);
    drive(1'b1, 1'b1, 32'd30);
    check("fe_pstart", bus.period_start_out, 1);
    check("fe_active", bus.active_width_out, 30);
    check("fe_clamped", bus.clamped_out, 0);

    // Drop enable at count 5: frame completes, then IDLE
    run_to_pos(5);
    bus.enable_in = 1'b0;
    k = 0;
    while (bus.busy_out === 1'b1 && k < 2 * int'(PERIOD)) begin
      step();
      k++;
    end
    check("drop_len", k, PERIOD - 5);
    repeat (5) step();
    check("idle_busy",  bus.busy_out, 0);
    check("idle_pulse", bus.pulse_out, 0);
    drive(1'b1, 1'b0, '0);
    check("rearm_pstart", bus.period_start_out, 1);
    check("rearm_pulse",  bus.pulse_out, 1);
    check("rearm_active", bus.active_width_out, 30);

    // Randomised enable toggling and writes against the model
    en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      logic [31:0] w;
      bit          wv;
      if ($urandom_range(0, 199) == 0) en = ~en;
      wv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       w = $urandom;
        1:       w = 32'(MIN_W - 1 + $urandom_range(0, 2));
        2:       w = 32'(MAX_W - 1 + $urandom_range(0, 2));
        default: w = 32'($urandom_range(0, 60));
      endcase
      drive(en, wv, w);
    end

    // Reset mid-frame while the pulse is high
    bus.enable_in = 1'b1;
    run_to_pos(3);
    check("pre_rst_pulse", bus.pulse_out, 1);
    #2;
    reset_n_in = 1'b0;
    model_reset();
    #1;
    check("async_rst_pulse",  bus.pulse_out, 0);
    check("async_rst_busy",   bus.busy_out, 0);
    check("async_rst_active", bus.active_width_out, MIN_W);
    bus.enable_in = 1'b0;
    @(negedge clk_in);
    repeat (2) step();
    reset_n_in = 1'b1;
    repeat (3) step();
    check("post_rst_busy",   bus.busy_out, 0);
    check("post_rst_active", bus.active_width_out, MIN_W);
    check("post_rst_pulse",  bus.pulse_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwmtx.md
Name: pwmtx

Overview:
- Servo-style PWM pulse generator; the transmit counterpart of the pulse-width receiver.
- Emits one high pulse per fixed frame: 20 ms at 25 MHz, i.e. 500000 clocks.
- Pulse width is given in clock counts; at defaults, 50000 = 2 ms.
- Width updates are double-buffered and take effect only at a frame boundary, so no glitched or runt pulses reach the servo/ESC pin.

Parameters:
- SIZE, 32: width of the width/counter datapath in bits.
- SYSCLK, 25000000: clock frequency in Hz. Documentation only; no logic derives from it.
- PERIOD, 500000: frame length in clocks (20 ms at SYSCLK).
- MIN_WIDTH, 25000: minimum pulse width in clocks (1 ms).
- MAX_WIDTH, 50000: maximum pulse width in clocks (2 ms).
- Required: 0 < MIN_WIDTH <= MAX_WIDTH < PERIOD <= 2^SIZE-1.

Ports:
- clk_in, input, 1: system clock.
- reset_n_in, input, 1: asynchronous active-low reset.
- enable_in, input, 1: level; request that frames be generated.
- width_in, input, SIZE: requested pulse width in clocks.
- width_valid_in, input, 1: one-cycle strobe; load width_in into the shadow register.
- pulse_out, output, 1: registered PWM output.
- period_start_out, output, 1: one-cycle strobe, high in the first cycle of every frame.
- active_width_out, output, SIZE: width in use for the current frame.
- clamped_out, output, 1: set if the last accepted write was clamped.
- busy_out, output, 1: high while in RUN.

Behaviour:
- Reset (async, reset_n_in low):
  - state = IDLE, count = 0.
  - pulse_out = 0, period_start_out = 0, clamped_out = 0, busy_out = 0.
  - shadow = active_width_out = MIN_WIDTH.
- Clamp: clamp(w) = MIN_WIDTH if w < MIN_WIDTH; MAX_WIDTH if w > MAX_WIDTH; otherwise w. Comparisons are unsigned, SIZE bits.
- Write: on an edge with width_valid_in = 1:
  - shadow <= clamp(width_in).
  - clamped_out <= 1 if a clamp was applied, else 0.
  - Accepted in any state. No backpressure.
  - next_shadow means the shadow value after this edge, so a write on a frame-start edge applies to that frame.
- State machine: two states, IDLE and RUN. busy_out = (state == RUN).
- IDLE:
  - pulse_out = 0, count held at 0.
  - On an edge with enable_in = 1: state <= RUN, count <= 0, active <= next_shadow, pulse_out <= 1, period_start_out <= 1.
- RUN, count != PERIOD-1:
  - count <= count+1.
  - pulse_out <= (count+1 < active).
  - period_start_out <= 0.
- RUN, count == PERIOD-1 (frame end):
  - If enable_in = 1: count <= 0, active <= next_shadow, pulse_out <= 1, period_start_out <= 1 (back-to-back frame).
  - If enable_in = 0: state <= IDLE, count <= 0, pulse_out <= 0, period_start_out <= 0.
- Resulting timing:
  - pulse_out is high for exactly active clocks, starting one edge after the start condition.
  - Frame-to-frame rising-edge spacing is exactly PERIOD clocks.
- Enable behaviour:
  - Dropping enable_in mid-frame never truncates a frame; the current frame always completes.
  - enable_in is sampled only in IDLE and at the frame-end edge.
- active_width_out is stable for the whole frame; it changes only on frame-start edges.
- Reset mid-frame: pulse_out drops immediately (async), and the block returns to IDLE.

Test Plan:
- Small parameters PERIOD=100, MIN_WIDTH=10, MAX_WIDTH=40. Reset, then enable_in=1 with no write → pulse high 10 clocks, low 90, repeating. period_start_out pulses every 100 clocks; busy_out = 1.
- Write width_in=25 mid-frame → current frame keeps its width (10 or prior). Next frame: pulse high 25 clocks, active_width_out = 25, clamped_out = 0.
- Write 5 → next frame width 10, clamped_out = 1. Write 1000 → next frame width 40, clamped_out = 1. Write 0 → width 10.
- Write 30 on the exact frame-end edge (count = 99) → the new frame already uses 30.
- Drop enable_in at count = 5 → frame completes (full pulse, 100 clocks), then IDLE with pulse_out = 0 and busy_out = 0. Re-raise enable_in → the next pulse starts one edge later with a period_start_out strobe.
- Assert reset_n_in low at count = 3 while pulse_out = 1 → pulse_out = 0 immediately. After release: IDLE, active_width_out = 10.
